// File: rtl/feature_row_buffer.sv
// Three-row sliding line buffer ahead of the 3x3 window expander: rows stream into a
// 4-bank ring and the expander reads the oldest, middle and newest rows in parallel.
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif
`ifndef PICTURE_NUM
`define PICTURE_NUM 1
`endif

module feature_row_buffer #(
  parameter int CHANNEL_IN_NUM     = 16,
  parameter int WIDTH_RAM_SIZE     = 12,
  parameter int WIDTH_FEATURE_SIZE = 12,
  parameter int WIDTH_CHANNEL_NUM  = 10,
  localparam int WD = `WIDTH_DATA * `PICTURE_NUM * CHANNEL_IN_NUM
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Start,
  input  logic [WIDTH_FEATURE_SIZE-1:0] Row_Num_After_Padding,
  input  logic [WIDTH_CHANNEL_NUM-1:0]  Channel_In_Num_REG,
  input  logic [WD-1:0]                 S_Data,
  input  logic                          S_Valid,
  output logic                          S_Ready,
  input  logic [WIDTH_RAM_SIZE-1:0]     Addr,
  output logic [3*WD-1:0]               S_Feature,
  output logic                          Row_Compute_Sign,
  input  logic                          M_Busy,
  output logic                          Frame_Done
);

  localparam int DEPTH       = 1 << WIDTH_RAM_SIZE;
  localparam int GROUP_SHIFT = $clog2(CHANNEL_IN_NUM);
  localparam int PW          = WIDTH_FEATURE_SIZE + WIDTH_CHANNEL_NUM;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                    state;
  logic [WIDTH_FEATURE_SIZE-1:0] row_count;
  logic [WIDTH_FEATURE_SIZE-1:0] rows_in;
  logic [WIDTH_FEATURE_SIZE-1:0] released;
  logic [WIDTH_RAM_SIZE-1:0]     last_addr;
  logic [WIDTH_RAM_SIZE-1:0]     wr_addr;
  logic [1:0]                    wr_bank;
  logic [1:0]                    rd_base;
  logic [1:0]                    rd_mid;
  logic [1:0]                    rd_new;
  logic [2:0]                    rows_full;
  logic                          m_busy_d;

  logic [WD-1:0] bank_mem [4][DEPTH];

  logic [WIDTH_CHANNEL_NUM-1:0] group_num;
  logic [PW-1:0]                words_per_row;
  logic [WIDTH_RAM_SIZE-1:0]    last_addr_next;
  logic                         in_fill;
  logic                         rel;
  logic                         rel_ok;
  logic                         wr_en;
  logic                         row_done;
  logic                         frame_end;

  // Row geometry is derived from the live inputs and only captured when a frame starts.
  assign group_num      = Channel_In_Num_REG >> GROUP_SHIFT;
  assign words_per_row  = PW'(Row_Num_After_Padding) * PW'(group_num);
  assign last_addr_next = WIDTH_RAM_SIZE'(words_per_row - PW'(1));

  assign in_fill   = (state == ST_FILL);
  assign rel       = m_busy_d & ~M_Busy;
  assign rel_ok    = rel && in_fill && (rows_full >= 3'd3);
  assign S_Ready   = in_fill && (rows_full < 3'd4) && (rows_in < row_count);
  assign wr_en     = S_Valid && S_Ready;
  assign row_done  = wr_en && (wr_addr == last_addr);
  assign frame_end = in_fill && (rows_in == row_count) &&
                     (released == row_count - WIDTH_FEATURE_SIZE'(2));

  // Dropping with the falling M_Busy keeps the expander off a triple that is being retired.
  assign Row_Compute_Sign = in_fill && (rows_full >= 3'd3) && !rel;
  assign Frame_Done       = (state == ST_DONE);

  assign rd_mid = rd_base + 2'd1;
  assign rd_new = rd_base + 2'd2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      row_count <= '0;
      last_addr <= '0;
      rows_in   <= '0;
      released  <= '0;
      wr_addr   <= '0;
      wr_bank   <= '0;
      rd_base   <= '0;
      rows_full <= '0;
      m_busy_d  <= 1'b0;
    end else begin
      m_busy_d <= M_Busy;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state     <= ST_FILL;
            row_count <= Row_Num_After_Padding;
            last_addr <= last_addr_next;
            rows_in   <= '0;
            released  <= '0;
            wr_addr   <= '0;
            wr_bank   <= '0;
            rd_base   <= '0;
            rows_full <= '0;
          end
        end
        ST_FILL: begin
          if (frame_end) begin
            state <= ST_DONE;
          end
          if (wr_en) begin
            if (row_done) begin
              wr_addr <= '0;
              wr_bank <= wr_bank + 2'd1;
              rows_in <= rows_in + WIDTH_FEATURE_SIZE'(1);
            end else begin
              wr_addr <= wr_addr + WIDTH_RAM_SIZE'(1);
            end
          end
          if (rel_ok) begin
            rd_base  <= rd_base + 2'd1;
            released <= released + WIDTH_FEATURE_SIZE'(1);
          end
          // A row landing in the same cycle as a release leaves the occupancy unchanged.
          case ({row_done, rel_ok})
            2'b10:   rows_full <= rows_full + 3'd1;
            2'b01:   rows_full <= rows_full - 3'd1;
            default: rows_full <= rows_full;
          endcase
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_mem[wr_bank][wr_addr] <= S_Data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      S_Feature <= '0;
    end else begin
      S_Feature <= {bank_mem[rd_new][Addr], bank_mem[rd_mid][Addr], bank_mem[rd_base][Addr]};
    end
  end

endmodule

// File: tb/tb_feature_row_buffer.sv
// Self-checking bench for feature_row_buffer; expected triples come from a row-indexed model
// (row number and word address), independent of the buffer's bank pointers.
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif
`ifndef PICTURE_NUM
`define PICTURE_NUM 1
`endif

module tb_feature_row_buffer;

  localparam int AW  = 12;
  localparam int FW  = 12;
  localparam int CW  = 10;
  localparam int CIN = 16;
  localparam int WD  = `WIDTH_DATA * `PICTURE_NUM * CIN;
  localparam int REP = WD / 32;

  typedef logic [3*WD-1:0] wide_t;

  typedef struct {
    logic [AW-1:0] addr;
    wide_t         expected;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          Start;
  logic [FW-1:0] Row_Num_After_Padding;
  logic [CW-1:0] Channel_In_Num_REG;
  logic [WD-1:0] S_Data;
  logic          S_Valid;
  logic          S_Ready;
  logic [AW-1:0] Addr;
  wide_t         S_Feature;
  logic          Row_Compute_Sign;
  logic          M_Busy;
  logic          Frame_Done;

  int    checks   = 0;
  int    failures = 0;
  wide_t exp_q[$];
  vec_t  vecs[5];

  feature_row_buffer #(
    .CHANNEL_IN_NUM    (CIN),
    .WIDTH_RAM_SIZE    (AW),
    .WIDTH_FEATURE_SIZE(FW),
    .WIDTH_CHANNEL_NUM (CW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .Start                (Start),
    .Row_Num_After_Padding(Row_Num_After_Padding),
    .Channel_In_Num_REG   (Channel_In_Num_REG),
    .S_Data               (S_Data),
    .S_Valid              (S_Valid),
    .S_Ready              (S_Ready),
    .Addr                 (Addr),
    .S_Feature            (S_Feature),
    .Row_Compute_Sign     (Row_Compute_Sign),
    .M_Busy               (M_Busy),
    .Frame_Done           (Frame_Done)
  );

  always #5 clk = ~clk;

  function automatic logic [WD-1:0] word_val(input int tag, input int row, input int a);
    logic [31:0] w;
    w = 32'h5A00_0000 ^ 32'(tag << 20) ^ 32'(row << 12) ^ 32'(a);
    return {REP{w}};
  endfunction

  function automatic wide_t exp_triple(input int tag, input int base, input int a);
    return {word_val(tag, base + 2, a), word_val(tag, base + 1, a), word_val(tag, base, a)};
  endfunction

  task automatic checkOutput(input string name, input wide_t actual, input wide_t expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Expected triple is queued when the address is driven and retired when S_Feature updates.
  task automatic applyStimulus(input string name, input int a, input wide_t expected);
    exp_q.push_back(expected);
    Addr = AW'(a);
    @(posedge clk); #1;
    checkOutput(name, S_Feature, exp_q.pop_front());
  endtask

  task automatic push_word(input logic [WD-1:0] d);
    int n = 0;
    S_Data  = d;
    S_Valid = 1'b1;
    while (!S_Ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checkOutput("push_timeout", wide_t'(S_Ready), wide_t'(1));
    end else begin
      @(posedge clk); #1;
    end
    S_Valid = 1'b0;
  endtask

  task automatic stream_words(input int tag, input int w, input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      push_word(word_val(tag, k / w, k % w));
    end
  endtask

  task automatic start_frame(input int r, input int ch);
    @(posedge clk); #1;
    Row_Num_After_Padding = FW'(r);
    Channel_In_Num_REG    = CW'(ch);
    Start                 = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    Start   = 1'b0;
    S_Valid = 1'b0;
    M_Busy  = 1'b0;
    Addr    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_s_ready", wide_t'(S_Ready), wide_t'(0));
    checkOutput("rst_rcs", wide_t'(Row_Compute_Sign), wide_t'(0));
    checkOutput("rst_s_feature", S_Feature, wide_t'(0));
    checkOutput("rst_frame_done", wide_t'(Frame_Done), wide_t'(0));
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int tag, input int glitch_word);
    int passes   = 0;
    int fd_count = 0;
    int w        = 5;
    start_frame(5, 16);
    fork
      begin
        for (int k = 0; k < 5 * w; k++) begin
          if (k == glitch_word) begin
            Start                 = 1'b1;
            Row_Num_After_Padding = FW'(7);
            Channel_In_Num_REG    = CW'(32);
          end
          push_word(word_val(tag, k / w, k % w));
          if (k == glitch_word) begin
            Start                 = 1'b0;
            Row_Num_After_Padding = FW'(5);
            Channel_In_Num_REG    = CW'(16);
          end
        end
      end
      begin
        bit done = 1'b0;
        while (!done && passes < 6) begin
          int n = 0;
          while (!Row_Compute_Sign && !Frame_Done && n < 400) begin
            @(posedge clk); #1;
            n++;
          end
          if (Frame_Done) begin
            done = 1'b1;
          end else if (!Row_Compute_Sign) begin
            checkOutput("expander_wait_timeout", wide_t'(Row_Compute_Sign), wide_t'(1));
            done = 1'b1;
          end else begin
            M_Busy = 1'b1;
            for (int a = 0; a < w; a++) begin
              applyStimulus($sformatf("frame%0d_pass%0d_addr%0d", tag, passes, a), a,
                            exp_triple(tag, passes, a));
            end
            M_Busy = 1'b0;
            #1;
            checkOutput($sformatf("frame%0d_rcs_drop%0d", tag, passes),
                        wide_t'(Row_Compute_Sign), wide_t'(0));
            passes++;
            @(posedge clk); #1;
          end
        end
      end
      begin
        repeat (400) begin
          @(posedge clk); #1;
          if (Frame_Done) fd_count++;
        end
      end
    join
    checkOutput("frame_passes", wide_t'(passes), wide_t'(3));
    checkOutput("frame_done_pulses", wide_t'(fd_count), wide_t'(1));
    checkOutput("frame_idle_s_ready", wide_t'(S_Ready), wide_t'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst                   = 1'b0;
    Start                 = 1'b0;
    S_Valid               = 1'b0;
    S_Data                = '0;
    M_Busy                = 1'b0;
    Addr                  = '0;
    Row_Num_After_Padding = '0;
    Channel_In_Num_REG    = '0;

    // Basic fill: R=5, G=1, three rows, then a table of parallel reads.
    for (int i = 0; i < 5; i++) begin
      vecs[i].addr     = AW'(i);
      vecs[i].expected = exp_triple(1, 0, i);
    end
    do_reset();
    start_frame(5, 16);
    stream_words(1, 5, 0, 14);
    checkOutput("fill_rcs_before_last", wide_t'(Row_Compute_Sign), wide_t'(0));
    stream_words(1, 5, 14, 1);
    checkOutput("fill_rcs_after_last", wide_t'(Row_Compute_Sign), wide_t'(1));
    checkOutput("fill_s_ready", wide_t'(S_Ready), wide_t'(1));
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("fill_read%0d", i), int'(vecs[i].addr), vecs[i].expected);
    end

    // Stall: R=6, G=2, four rows fill the ring, one release frees a bank.
    do_reset();
    start_frame(6, 32);
    stream_words(2, 12, 0, 48);
    checkOutput("stall_s_ready_low", wide_t'(S_Ready), wide_t'(0));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_s_ready_held", wide_t'(S_Ready), wide_t'(0));
    checkOutput("stall_rcs", wide_t'(Row_Compute_Sign), wide_t'(1));
    M_Busy = 1'b1;
    @(posedge clk); #1;
    M_Busy = 1'b0;
    #1;
    checkOutput("stall_rcs_on_rel", wide_t'(Row_Compute_Sign), wide_t'(0));
    @(posedge clk); #1;
    checkOutput("stall_s_ready_back", wide_t'(S_Ready), wide_t'(1));
    checkOutput("stall_rcs_back", wide_t'(Row_Compute_Sign), wide_t'(1));
    applyStimulus("stall_read0", 0, exp_triple(2, 1, 0));
    applyStimulus("stall_read7", 7, exp_triple(2, 1, 7));
    applyStimulus("stall_read11", 11, exp_triple(2, 1, 11));

    // Full frames with a model expander, the second with a stray Start mid-frame.
    do_reset();
    run_frame(3, -1);
    run_frame(6, 7);

    // Last word of row 4 accepted in the same cycle as a release.
    do_reset();
    start_frame(6, 16);
    stream_words(4, 6, 0, 18);
    checkOutput("sim_rcs_ready", wide_t'(Row_Compute_Sign), wide_t'(1));
    M_Busy = 1'b1;
    stream_words(4, 6, 18, 5);
    S_Data  = word_val(4, 3, 5);
    S_Valid = 1'b1;
    M_Busy  = 1'b0;
    #1;
    checkOutput("sim_rcs_low", wide_t'(Row_Compute_Sign), wide_t'(0));
    checkOutput("sim_s_ready_before", wide_t'(S_Ready), wide_t'(1));
    @(posedge clk); #1;
    S_Valid = 1'b0;
    checkOutput("sim_rcs_back", wide_t'(Row_Compute_Sign), wide_t'(1));
    checkOutput("sim_rows_full_3", wide_t'(S_Ready), wide_t'(1));
    applyStimulus("sim_read0", 0, exp_triple(4, 1, 0));
    applyStimulus("sim_read5", 5, exp_triple(4, 1, 5));

    // Asynchronous reset during the second row, then a clean refill.
    do_reset();
    start_frame(5, 16);
    stream_words(5, 5, 0, 8);
    checkOutput("mid_s_ready_pre", wide_t'(S_Ready), wide_t'(1));
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_s_ready", wide_t'(S_Ready), wide_t'(0));
    checkOutput("async_rst_rcs", wide_t'(Row_Compute_Sign), wide_t'(0));
    checkOutput("async_rst_s_feature", S_Feature, wide_t'(0));
    checkOutput("async_rst_frame_done", wide_t'(Frame_Done), wide_t'(0));
    #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vecs[i].addr     = AW'(4 - i);
      vecs[i].expected = exp_triple(7, 0, 4 - i);
    end
    start_frame(5, 16);
    stream_words(7, 5, 0, 15);
    checkOutput("refill_rcs", wide_t'(Row_Compute_Sign), wide_t'(1));
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("refill_read%0d", i), int'(vecs[i].addr), vecs[i].expected);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/feature_row_buffer.md
# feature_row_buffer

Three-row sliding line buffer that sits directly upstream of the 3x3 window expander. It accepts the padded input feature map as a stream of channel-group words, stores rows in a 4-bank ring, and raises `Row_Compute_Sign` whenever three consecutive rows are resident. The expander then reads all three rows in parallel through `Addr`. Each time the expander finishes a row pass, the oldest row is released (vertical stride 1), freeing a bank for the next incoming row.

## Interface
Parameters:
- `CHANNEL_IN_NUM`, 16: channels per word; must be a power of two.
- `WIDTH_RAM_SIZE`, 12: bank address width.
- `WIDTH_FEATURE_SIZE`, 12: row/column count width.
- `WIDTH_CHANNEL_NUM`, 10: input channel count width.
- Derived `WD` = `WIDTH_DATA`*`PICTURE_NUM`*`CHANNEL_IN_NUM`, using the global `WIDTH_DATA` and `PICTURE_NUM` macros.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `Start` in 1: frame start pulse; sampled only in IDLE.
- `Row_Num_After_Padding` in `WIDTH_FEATURE_SIZE`: padded row length, equal to the padded row count.
- `Channel_In_Num_REG` in `WIDTH_CHANNEL_NUM`: input channels, a multiple of `CHANNEL_IN_NUM`.
- `S_Data` in `WD`: incoming word.
- `S_Valid` in 1: `S_Data` valid.
- `S_Ready` out 1: buffer accepts a word this cycle.
- `Addr` in `WIDTH_RAM_SIZE`: read address from the expander.
- `S_Feature` out 3*`WD`: bits [WD-1:0] hold the oldest row, [2WD-1:WD] the middle row, [3WD-1:2WD] the newest row.
- `Row_Compute_Sign` out 1: a row triple is available.
- `M_Busy` in 1: the expander's `S_Ready`; a falling edge means the triple has been consumed.
- `Frame_Done` out 1: one-cycle pulse when the frame is fully consumed.

## Operation
- **Word geometry:**
  - G = `Channel_In_Num_REG` >> log2(`CHANNEL_IN_NUM`).
  - W = `Row_Num_After_Padding`*G words per row.
  - Word address = column*G + group, in the range 0..W-1.
  - W is guaranteed ≤ 2^`WIDTH_RAM_SIZE`.
- **States:**
  - IDLE -> FILL on `Start`. `Row_Num_After_Padding` and G are latched; all counters and pointers are cleared.
  - FILL -> DONE when rows_in == R (R = latched row count) and released == R-2.
  - DONE -> IDLE unconditionally after one cycle; `Frame_Done` = 1 during DONE.
- **Write side:**
  - `S_Ready` = FILL && rows_full < 4 && rows_in < R.
  - On `S_Valid`&&`S_Ready`: write bank[wr_bank][wr_addr]; wr_addr++.
  - At wr_addr == W-1: wr_addr <= 0, wr_bank <= wr_bank+1 (mod 4), rows_in++, rows_full++.
- **Release:**
  - rel = `M_Busy`_d & ~`M_Busy`, where `M_Busy`_d is `M_Busy` registered.
  - On rel: rd_base <= rd_base+1 (mod 4), rows_full--, released++.
- **Simultaneous row-complete and rel:** rows_full holds; both pointers advance.
- **Row_Compute_Sign:**
  - Equals (state==FILL && rows_full ≥ 3) & ~rel, where rows_full is the registered value.
  - It drops combinationally in the cycle `M_Busy` falls. The expander therefore never re-enters a pass on a stale triple.
- **Read side:** `S_Feature` is registered: {bank[rd_base+2][Addr], bank[rd_base+1][Addr], bank[rd_base][Addr]}, with bank indices mod 4.
- **Counter bounds:**
  - rows_full is never above 4 and never decremented below 0.
  - A rel while rows_full < 3 is a protocol error and is ignored.
- **Reset:**
  - Any time `rst` is low: state=IDLE, all pointers and counters 0.
  - `S_Ready`=0, `Row_Compute_Sign`=0, `S_Feature`=0, `Frame_Done`=0.
  - Bank contents are not cleared.
- **Start outside IDLE:** ignored.

## Timing
- Read latency: `Addr` at edge n -> `S_Feature` valid after edge n+1. This matches the expander's two-stage write-enable delay.
- Write-to-read: a word written at edge n is readable by an `Addr` presented from edge n+1 onward.
- `Row_Compute_Sign` rises the cycle after the third row's last word is accepted.
- Fourth-bank behaviour:
  - Row 4 streams while rows 1-3 are being read.
  - Once rows_full == 4, `S_Ready` stays low until the next rel.
- Throughput: one word per cycle when not stalled.

## Test plan
- **Basic fill:** R=5, Channel_In_Num_REG=16 (G=1, W=5). Stream 15 words with `M_Busy`=0 throughout.
  - `Row_Compute_Sign` rises one cycle after word 15.
  - `Addr`=2 returns {row2[2], row1[2], row0[2]} one cycle later.
- **Stall:** R=6, G=2. Stream all words with `M_Busy` held 0.
  - `S_Ready` drops after word 48 (4 rows).
  - A 1->0 pulse on `M_Busy` re-raises `S_Ready` next cycle.
  - The next `Addr` read returns rows 1-3.
- **Full frame:** R=5 with a model expander.
  - Exactly 3 release edges occur.
  - `Frame_Done` pulses once, then state returns to IDLE; `S_Ready`=0.
- **Simultaneous events:** the last word of row 4 is accepted in the same cycle as rel.
  - rows_full stays 3.
  - `Row_Compute_Sign` is low for that cycle only.
- **Reset mid-frame:** drop `rst` during row 2.
  - All outputs go 0 asynchronously.
  - A new `Start` refills correctly from bank 0.
- **Start while in FILL:** pulse `Start` mid-frame.
  - Pointers are unchanged.
  - The frame completes normally.
